// File: rtl/imem_responder.sv
// Instruction-memory responder: answers core fetches (pc -> inst) from a word array after a
// fixed wait. A backdoor port fills the array. Bad fetches return rdata=0 with resp_err=1.
module imem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] r_addr;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH];

   logic             w_accept;
   logic             w_enter_resp;
   logic [31:0]      w_rd_addr;
   logic [IDX_W-1:0] w_rd_idx;
   logic             w_rd_bad;
   logic [IDX_W-1:0] w_ld_idx;
   logic             w_ld_bad;

   function automatic logic [31:0] word_idx(input logic [31:0] addr);
      return (addr - BASE) >> 2;
   endfunction

   // Below BASE the subtraction wraps, so the lower-bound compare must stay explicit.
   function automatic logic addr_bad(input logic [31:0] addr);
      logic [31:0] idx;
      idx = word_idx(addr);
      return (addr < BASE) || (idx >= 32'(DEPTH)) || (addr[1:0] != 2'b00);
   endfunction

   // Held low throughout reset even though the state register already reads IDLE.
   assign req_ready  = (r_state == S_IDLE) && rst_n;
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   assign w_accept = req_valid && req_ready;

   // With zero latency the array is read in the accept cycle, before r_addr holds the pc.
   assign w_rd_addr = (r_state == S_IDLE) ? req_addr : r_addr;
   assign w_rd_idx  = IDX_W'(word_idx(w_rd_addr));
   assign w_rd_bad  = addr_bad(w_rd_addr);
   assign w_ld_idx  = IDX_W'(word_idx(load_addr));
   assign w_ld_bad  = addr_bad(load_addr);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 0) begin
                  w_state_nxt  = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = 4'(LATENCY);
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt  = S_RESP;
               w_enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_addr <= req_addr;
         end
         if (w_enter_resp) begin
            r_err   <= w_rd_bad;
            r_rdata <= w_rd_bad ? 32'd0 : r_mem[w_rd_idx];
         end
      end
   end

   // NOTE: the array has no reset; its contents must survive rst_n and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (load_en && !w_ld_bad) begin
         r_mem[w_ld_idx] <= load_data;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (LATENCY 1, 0, 15) share clock, reset
// and the load bus; each has its own fetch/response channel and expected-response queue.
module tb_imem_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid  [3];
   logic [31:0] req_addr   [3];
   logic        req_ready  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q  [3][$];
   int          acc_q [3][$];
   logic [31:0] model [int];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) u_dut_l0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(15)) u_dut_l15 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[2]), .req_addr(req_addr[2]), .req_ready(req_ready[2]),
      .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 0;
         default: return 15;
      endcase
   endfunction

   function automatic logic bad_addr(input logic [31:0] a);
      return (a < BASE) || (a >= TOP) || (a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] expect_word(input logic [31:0] a);
      int idx;
      if (bad_addr(a)) return 32'd0;
      idx = int'((a - BASE) >> 2);
      return model.exists(idx) ? model[idx] : 32'd0;
   endfunction

   // Response monitor per instance: checks latency on each rising resp_valid, pops the
   // scoreboard on every handshake and expects req_ready back on the following cycle.
   for (genvar k = 0; k < 3; k++) begin : g_mon
      logic prev_valid = 1'b0;
      logic chk_ready  = 1'b0;
      int   a_cyc;
      exp_t x;
      always begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            sb_q[k].delete();
            acc_q[k].delete();
            prev_valid = 1'b0;
            chk_ready  = 1'b0;
         end else begin
            if (chk_ready) begin
               check($sformatf("ready_back%0d", k), 32'(req_ready[k]), 32'd1);
               chk_ready = 1'b0;
            end
            if (resp_valid[k] && !prev_valid) begin
               if (acc_q[k].size() == 0) begin
                  check($sformatf("spurious_resp%0d", k), 32'd1, 32'd0);
               end else begin
                  a_cyc = acc_q[k].pop_front();
                  check($sformatf("latency%0d", k), 32'(cyc + 1 - a_cyc), 32'(lat_of(k) + 1));
               end
            end
            if (resp_valid[k] && resp_ready[k]) begin
               if (sb_q[k].size() == 0) begin
                  check($sformatf("unexpected_hs%0d", k), 32'd1, 32'd0);
               end else begin
                  x = sb_q[k].pop_front();
                  check($sformatf("rdata%0d", k), resp_rdata[k], x.data);
                  check($sformatf("err%0d", k), 32'(resp_err[k]), 32'(x.err));
               end
               chk_ready = 1'b1;
            end
            prev_valid = resp_valid[k];
         end
      end
   end

   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic e, output int acc);
      exp_t x;
      logic got;
      x.data = d;
      x.err  = e;
      sb_q[k].push_back(x);
      got = 1'b0;
      acc = -1;
      req_valid[k] = 1'b1;
      req_addr[k]  = a;
      for (int i = 0; i < 400 && !got; i++) begin
         if (req_ready[k]) begin
            acc = cyc + 1;
            got = 1'b1;
            acc_q[k].push_back(acc);
         end
         @(negedge clk);
      end
      if (!got) check($sformatf("accept_timeout%0d", k), 32'd0, 32'd1);
      req_valid[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (sb_q[k].size() == 0 && req_ready[k]) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) check($sformatf("drain_timeout%0d", k), 32'd0, 32'd1);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      if (!bad_addr(a)) model[int'((a - BASE) >> 2)] = d;
   endtask

   task automatic fetch(input int k, input logic [31:0] a);
      int acc;
      issue(k, a, expect_word(a), bad_addr(a), acc);
      wait_done(k);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc;
      int   a0, a1, a2;
      logic ok;
      for (int k = 0; k < 3; k++) begin
         req_valid[k]  = 1'b0;
         req_addr[k]   = 32'd0;
         resp_ready[k] = 1'b1;
      end
      load_en   = 1'b0;
      load_addr = 32'd0;
      load_data = 32'd0;

      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_req_ready", 32'(req_ready[k]), 32'd0);
         check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
         check("rst_rdata", resp_rdata[k], 32'd0);
         check("rst_err", 32'(resp_err[k]), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) check("post_rst_ready", 32'(req_ready[k]), 32'd1);
      @(negedge clk);

      // First fetch, then fill a handful of words and try loads that must be dropped.
      do_load(BASE, 32'h0010_0093);
      fetch(0, BASE);
      do_load(BASE + 32'h4, 32'h0020_0113);
      do_load(BASE + 32'h8, 32'h0030_0193);
      do_load(BASE + 32'h10, 32'hDEAD_BEEF);
      do_load(TOP - 32'h4, 32'h1234_5678);
      do_load(BASE + 32'h12, 32'hBAD0_BAD0);
      do_load(TOP, 32'hBAD1_BAD1);
      do_load(32'h7FFF_FFFC, 32'hBAD2_BAD2);
      fetch(0, BASE);
      fetch(0, BASE + 32'h10);
      fetch(0, TOP - 32'h4);
      fetch(0, BASE + 32'h2);
      fetch(0, 32'h7FFF_FFFC);
      fetch(0, TOP);

      // Consumer stall: response must hold while a second request is ignored.
      resp_ready[0] = 1'b0;
      issue(0, BASE + 32'h4, 32'h0020_0113, 1'b0, acc);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (resp_valid[0]) ok = 1'b1;
         else @(negedge clk);
      end
      check("stall_wait", 32'(ok), 32'd1);
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE + 32'h8;
      repeat (5) begin
         check("stall_valid", 32'(resp_valid[0]), 32'd1);
         check("stall_rdata", resp_rdata[0], 32'h0020_0113);
         check("stall_req_ready", 32'(req_ready[0]), 32'd0);
         @(negedge clk);
      end
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      wait_done(0);
      repeat (3) @(negedge clk);
      check("no_extra_resp", 32'(resp_valid[0]), 32'd0);

      // Back-to-back throughput at both latency extremes.
      for (int k = 1; k < 3; k++) begin
         issue(k, BASE, expect_word(BASE), 1'b0, a0);
         issue(k, BASE + 32'h4, expect_word(BASE + 32'h4), 1'b0, a1);
         issue(k, BASE + 32'h8, expect_word(BASE + 32'h8), 1'b0, a2);
         check($sformatf("spacing_a%0d", k), 32'(a1 - a0), 32'(lat_of(k) + 2));
         check($sformatf("spacing_b%0d", k), 32'(a2 - a1), 32'(lat_of(k) + 2));
         wait_done(k);
      end

      // Load lands on the RESP-entry edge: old word returned, then new word on reissue.
      issue(0, BASE + 32'h8, expect_word(BASE + 32'h8), 1'b0, acc);
      do_load(BASE + 32'h8, 32'hCAFE_F00D);
      wait_done(0);
      fetch(0, BASE + 32'h8);

      // Load during a long wait is visible in the response; rdata then holds.
      issue(2, BASE + 32'h10, 32'h0BAD_F00D, 1'b0, acc);
      do_load(BASE + 32'h10, 32'h0BAD_F00D);
      wait_done(2);
      repeat (2) @(negedge clk);
      check("rdata_hold", resp_rdata[2], 32'h0BAD_F00D);

      // Reset during WAIT drops the fetch; array contents survive.
      issue(2, BASE + 32'h4, expect_word(BASE + 32'h4), 1'b0, acc);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("wait_rst_ready", 32'(req_ready[k]), 32'd0);
         check("wait_rst_valid", 32'(resp_valid[k]), 32'd0);
      end
      check("wait_rst_rdata", resp_rdata[2], 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("wait_rst_release", 32'(req_ready[2]), 32'd1);
      repeat (20) @(negedge clk);
      check("wait_rst_no_resp", 32'(resp_valid[2]), 32'd0);
      fetch(2, BASE);
      fetch(0, BASE + 32'h8);
      fetch(1, TOP - 32'h4);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
